// File: rtl/fetch_queue_if.sv
// Bundle between the fetch queue, instruction SRAM, EXE redirect and ID.
// The master modport is the fetch queue. The slave modport is its surroundings:
// the SRAM wrapper, the EXE stage and the ID stage.
interface fetch_queue_if #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int IM_ADDR_W = 14
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // Branch/jump redirect from EXE
    logic                  redirect_valid;
    logic [ADDR_W-1:0]     redirect_pc;

    // Dequeue handshake towards ID
    logic                  deq_ready;
    logic                  deq_valid;
    logic [DATA_W-1:0]     deq_instr;
    logic [ADDR_W-1:0]     deq_pc;

    // Instruction SRAM port
    logic                  im_cs;
    logic [IM_ADDR_W-1:0]  im_addr;
    logic [DATA_W-1:0]     im_rdata;

    // Status
    logic [OCC_W-1:0]      occupancy;

    modport master (
        input  redirect_valid, redirect_pc, deq_ready, im_rdata,
        output deq_valid, deq_instr, deq_pc, im_cs, im_addr, occupancy
    );

    modport slave (
        output redirect_valid, redirect_pc, deq_ready, im_rdata,
        input  deq_valid, deq_instr, deq_pc, im_cs, im_addr, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry instruction prefetch queue between the instruction
// SRAM and the ID stage. Each queue entry holds an instruction and its PC.
// The queue keeps fetching while ID stalls and flushes when EXE redirects.
// A request is issued only while count + in-flight < DEPTH. That reserves a
// slot for every outstanding response, so no response is ever dropped.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a
// response that arrives while the queue is empty is shown at deq_* in the same
// cycle. If ID takes it, the response never enters the queue.
// DEPTH must be a power of two and at least 2. The pointers wrap naturally.
module fetch_queue #(
    parameter int                DEPTH     = 4,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                IM_ADDR_W = 14,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetchPc_q,  fetchPc_d;
    logic              reqValid_q, reqValid_d;
    logic [ADDR_W-1:0] reqPc_q,    reqPc_d;
    logic [PTR_W-1:0]  wrPtr_q,    wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q,    rdPtr_d;
    logic [CNT_W-1:0]  count_q,    count_d;

    logic [DATA_W-1:0] instrMem_q [DEPTH];
    logic [ADDR_W-1:0] pcMem_q    [DEPTH];

    logic              issue;
    logic [CNT_W:0]    pending;
    logic              headValid;
    logic              respValid;
    logic              bypassHit;
    logic              enqueue;
    logic              dequeue;

    // The redirect target is word aligned. Its two low bits are deliberately dropped.
    logic              unusedRedirectLsbs;
    assign unusedRedirectLsbs = ^bus.redirect_pc[1:0];

    // Issue a fetch only when a queue slot is free for the response, and never while redirecting or in reset.
    always_comb begin
        pending = {1'b0, count_q} + {{CNT_W{1'b0}}, reqValid_q};
        issue   = rst & ~bus.redirect_valid & (pending < (CNT_W + 1)'(DEPTH));
    end

    assign bus.im_cs     = issue;
    assign bus.im_addr   = fetchPc_q[IM_ADDR_W+1:2];
    assign bus.occupancy = count_q;

    // Head selection, plus the enqueue/dequeue decisions. The optional bypass is resolved here.
    always_comb begin
        headValid     = (count_q != '0);
        respValid     = reqValid_q & ~bus.redirect_valid;
        bypassHit     = 1'b0;
        bus.deq_valid = headValid;
        bus.deq_instr = instrMem_q[rdPtr_q];
        bus.deq_pc    = pcMem_q[rdPtr_q];
`ifdef FETCH_QUEUE_BYPASS_EN
        bypassHit = respValid & ~headValid;
        if (bypassHit) begin
            bus.deq_valid = 1'b1;
            bus.deq_instr = bus.im_rdata;
            bus.deq_pc    = reqPc_q;
        end
`endif
        enqueue = respValid & ~(bypassHit & bus.deq_ready);
        dequeue = headValid & bus.deq_ready & ~bus.redirect_valid;
    end

    // Next state. A redirect flushes everything. Otherwise the fetch PC advances on issue and the pointers follow the handshakes.
    always_comb begin
        fetchPc_d  = fetchPc_q;
        reqValid_d = 1'b0;
        reqPc_d    = reqPc_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        if (bus.redirect_valid) begin
            fetchPc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
        end else begin
            if (issue) begin
                reqValid_d = 1'b1;
                reqPc_d    = fetchPc_q;
                fetchPc_d  = fetchPc_q + ADDR_W'(4);
            end
            if (enqueue) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (dequeue) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({enqueue, dequeue})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register. Reset is asynchronous, so it drops any in-flight response at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc_q  <= RESET_PC;
            reqValid_q <= 1'b0;
            reqPc_q    <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            fetchPc_q  <= fetchPc_d;
            reqValid_q <= reqValid_d;
            reqPc_q    <= reqPc_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage has no reset. Entries are only read when count says they hold data.
    always_ff @(posedge clk) begin
        if (enqueue) begin
            instrMem_q[wrPtr_q] <= bus.im_rdata;
            pcMem_q[wrPtr_q]    <= reqPc_q;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue in its default build, with the bypass disabled.
// The bench has three parts:
//   1. A hand-computed vector table: fill, stall, full boundary, redirect and PC wrap.
//   2. An asynchronous reset in the middle of a stream.
//   3. A randomized run checked against a transaction-level queue model.
module tb_fetch_queue;
    localparam int DEPTH     = 4;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int IM_ADDR_W = 14;

    logic clk;
    logic rst;

    int checks;
    int errors;

    fetch_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IM_ADDR_W(IM_ADDR_W)) bus ();

    fetch_queue #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IM_ADDR_W(IM_ADDR_W), .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each SRAM word holds a distinct addi that encodes its own word address.
    function automatic logic [31:0] memWord(input logic [13:0] a);
        return {a, 18'h00013};
    endfunction

    // SRAM model with one cycle of latency. Cycles without a request return random garbage, so stale data cannot pass unnoticed.
    always @(posedge clk) begin
        if (bus.im_cs) bus.im_rdata <= memWord(bus.im_addr);
        else           bus.im_rdata <= $urandom;
    end

    typedef struct {
        bit          redirect;
        logic [31:0] rpc;
        bit          ready;
        bit          expCs;
        logic [13:0] expAddr;
        bit          expValid;
        logic [31:0] expPc;
        int          expOcc;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mkVec(bit rd, logic [31:0] rpc, bit rdy, bit cs, logic [13:0] a,
                                   bit v, logic [31:0] pc, int occ);
        vec_t t;
        t.redirect = rd; t.rpc = rpc; t.ready = rdy;
        t.expCs = cs; t.expAddr = a; t.expValid = v; t.expPc = pc; t.expOcc = occ;
        return t;
    endfunction

    // Reference model: the queue holds the PCs of buffered entries, plus one in-flight slot and the next fetch PC.
    logic [31:0] mq[$];
    bit          mInflight;
    logic [31:0] mInflightPc;
    logic [31:0] mFetch;

    task automatic modelClear();
        mq.delete();
        mInflight   = 1'b0;
        mInflightPc = '0;
        mFetch      = 32'h0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge and let combinational outputs settle.
    task automatic applyStimulus(input bit rd, input logic [31:0] rpc, input bit rdy);
        @(negedge clk);
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        bus.deq_ready      = rdy;
        #1;
    endtask

    // Hold reset, check the reset state, then release just after a rising edge.
    task automatic applyReset();
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_ready      = 1'b0;
        #1;
        checkOutput("reset_deq_valid", bus.deq_valid, 0);
        checkOutput("reset_occupancy", bus.occupancy, 0);
        checkOutput("reset_im_cs", bus.im_cs, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        modelClear();
    endtask

    // Assert reset between clock edges and check that it clears the outputs asynchronously.
    task automatic resetMidStream(input int expOcc);
        @(posedge clk);
        #2;
        if (expOcc >= 0) checkOutput("pre_reset_occupancy", bus.occupancy, expOcc);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_deq_valid", bus.deq_valid, 0);
        checkOutput("async_reset_occupancy", bus.occupancy, 0);
        checkOutput("async_reset_im_cs", bus.im_cs, 0);
        bus.redirect_valid = 1'b0;
        bus.deq_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        modelClear();
    endtask

    // One cycle against the model: compare the settled outputs, then advance the model across the rising edge.
    task automatic modelStep(input bit rd, input logic [31:0] rpc, input bit rdy);
        int          sz;
        bit          expCs;
        logic [31:0] head;
        applyStimulus(rd, rpc, rdy);
        sz    = mq.size();
        expCs = !rd && (sz + int'(mInflight) < DEPTH);
        checkOutput("im_cs", bus.im_cs, expCs);
        if (expCs) checkOutput("im_addr", bus.im_addr, mFetch[15:2]);
        checkOutput("deq_valid", bus.deq_valid, sz != 0);
        if (sz != 0) begin
            head = mq[0];
            checkOutput("deq_pc", bus.deq_pc, head);
            checkOutput("deq_instr", bus.deq_instr, memWord(head[15:2]));
        end
        checkOutput("occupancy", bus.occupancy, sz);
        if (rd) begin
            mq.delete();
            mInflight = 1'b0;
            mFetch    = {rpc[31:2], 2'b00};
        end else begin
            if (rdy && sz != 0) void'(mq.pop_front());
            if (mInflight) mq.push_back(mInflightPc);
            mInflight = expCs;
            if (expCs) begin
                mInflightPc = mFetch;
                mFetch      = mFetch + 32'd4;
            end
        end
    endtask

    initial begin
        int readyPct;
        checks = 0;
        errors = 0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_ready      = 1'b0;
        rst = 1'b1;
        #1;

        // Fields: redirect, redirect_pc, ready | im_cs, im_addr, deq_valid, deq_pc, occupancy
        vecs[0]  = mkVec(0, 32'h0, 0, 1, 14'h0,    0, 32'h0, 0);
        vecs[1]  = mkVec(0, 32'h0, 0, 1, 14'h1,    0, 32'h0, 0);
        vecs[2]  = mkVec(0, 32'h0, 0, 1, 14'h2,    1, 32'h0, 1);
        vecs[3]  = mkVec(0, 32'h0, 0, 1, 14'h3,    1, 32'h0, 2);
        vecs[4]  = mkVec(0, 32'h0, 0, 0, 14'h0,    1, 32'h0, 3);
        vecs[5]  = mkVec(0, 32'h0, 0, 0, 14'h0,    1, 32'h0, 4);
        vecs[6]  = mkVec(0, 32'h0, 1, 0, 14'h0,    1, 32'h0, 4);
        vecs[7]  = mkVec(0, 32'h0, 0, 1, 14'h4,    1, 32'h4, 3);
        vecs[8]  = mkVec(0, 32'h0, 1, 0, 14'h0,    1, 32'h4, 3);
        vecs[9]  = mkVec(0, 32'h0, 1, 1, 14'h5,    1, 32'h8, 3);
        vecs[10] = mkVec(0, 32'h0, 1, 1, 14'h6,    1, 32'hC, 2);
        vecs[11] = mkVec(0, 32'h0, 1, 1, 14'h7,    1, 32'h10, 2);
        vecs[12] = mkVec(0, 32'h0, 1, 1, 14'h8,    1, 32'h14, 2);
        vecs[13] = mkVec(1, 32'h103, 1, 0, 14'h0,  1, 32'h18, 2);
        vecs[14] = mkVec(0, 32'h0, 1, 1, 14'h40,   0, 32'h0, 0);
        vecs[15] = mkVec(0, 32'h0, 1, 1, 14'h41,   0, 32'h0, 0);
        vecs[16] = mkVec(0, 32'h0, 1, 1, 14'h42,   1, 32'h100, 1);
        vecs[17] = mkVec(1, 32'hFFFFFFFE, 1, 0, 14'h0, 1, 32'h104, 1);
        vecs[18] = mkVec(0, 32'h0, 1, 1, 14'h3FFF, 0, 32'h0, 0);
        vecs[19] = mkVec(0, 32'h0, 1, 1, 14'h0,    0, 32'h0, 0);
        vecs[20] = mkVec(0, 32'h0, 1, 1, 14'h1,    1, 32'hFFFFFFFC, 1);

        // Directed table: fill, stall to full, dequeue at full, wrap, redirect, PC wrap
        applyReset();
        for (int i = 0; i < 21; i++) begin
            logic [31:0] pcTmp;
            applyStimulus(vecs[i].redirect, vecs[i].rpc, vecs[i].ready);
            pcTmp = vecs[i].expPc;
            checkOutput($sformatf("vec%0d_im_cs", i), bus.im_cs, vecs[i].expCs);
            if (vecs[i].expCs) checkOutput($sformatf("vec%0d_im_addr", i), bus.im_addr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_deq_valid", i), bus.deq_valid, vecs[i].expValid);
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_deq_pc", i), bus.deq_pc, pcTmp);
                checkOutput($sformatf("vec%0d_deq_instr", i), bus.deq_instr, memWord(pcTmp[15:2]));
            end
            checkOutput($sformatf("vec%0d_occupancy", i), bus.occupancy, vecs[i].expOcc);
        end

        // Reset asserted mid-stream at occupancy 2, then fetch restarts at RESET_PC
        applyReset();
        for (int i = 0; i < 3; i++) modelStep(1'b0, 32'h0, 1'b0);
        resetMidStream(2);
        for (int i = 0; i < 4; i++) modelStep(1'b0, 32'h0, 1'b1);

        // Randomized traffic: redirects, stall bursts and occasional asynchronous resets
        applyReset();
        readyPct = 60;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) readyPct = ($urandom_range(0, 1) == 1) ? 90 : 25;
            if ($urandom_range(0, 199) == 0) begin
                resetMidStream(-1);
            end else begin
                modelStep($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 99) < readyPct);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
